carfield_domain_seq: RTL



---
 rtl/carfield_domain_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/carfield_domain_seq.sv
// carfield_domain_seq: per-domain clock-enable / reset sequencer for Carfield's gateable subdomains
// One Moore FSM per domain (OFF, CLK_EN, ON, SW_RST, RST_ASSERT) orders clock enable,
// reset release, reset assertion and clock gating using programmable down-counters.
// Ports:
//   clk_i            system clock
//   rst_i            synchronous active-high reset; all FSMs to OFF, counters to 0
//   en_req_i         per-domain level request (1 = on), OR'ed with AlwaysOn
//   sw_rst_i         per-domain warm-reset pulse, honoured only in ON
//   clk_cycles_i     clock-run cycles before reset release, minus 1 (sampled on CLK_EN entry)
//   rst_cycles_i     reset-hold cycles with clock running, minus 1 (sampled on SW_RST/RST_ASSERT entry)
//   domain_clk_en_o  clock-gate enable per domain
//   domain_rst_no    active-low domain reset per domain
//   active_o         domain is ON
//   busy_o           domain is mid-sequence
// Option: define CARFIELD_DOMAIN_SEQ_SERIAL_EN to allow only one busy domain at a time.
module carfield_domain_seq #(
  parameter int unsigned NumDomains = 6,
  parameter int unsigned CntWidth = 8,
  parameter logic [NumDomains-1:0] AlwaysOn = 6'b000001
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumDomains-1:0] en_req_i,
  input  logic [NumDomains-1:0] sw_rst_i,
  input  logic [CntWidth-1:0]   clk_cycles_i,
  input  logic [CntWidth-1:0]   rst_cycles_i,
  output logic [NumDomains-1:0] domain_clk_en_o,
  output logic [NumDomains-1:0] domain_rst_no,
  output logic [NumDomains-1:0] active_o,
  output logic [NumDomains-1:0] busy_o
);
  typedef enum logic [2:0] {OFF, CLK_EN, ON, SW_RST, RST_ASSERT} state_e;
  state_e state_q [NumDomains];
  state_e state_n [NumDomains];
  logic [CntWidth-1:0] cnt_q [NumDomains];
  logic [CntWidth-1:0] cnt_n [NumDomains];
  logic [NumDomains-1:0] eff_en, want, grant, hold;
  assign eff_en = en_req_i | AlwaysOn;
  // Unconstrained next state; want marks domains trying to leave OFF or ON.
  always_comb begin
    want = '0;
    for (int d = 0; d < NumDomains; d++) begin
      state_n[d] = state_q[d];
      cnt_n[d] = (cnt_q[d] != '0) ? cnt_q[d] - 1'b1 : cnt_q[d];
      case (state_q[d])
        OFF: if (eff_en[d]) begin
          state_n[d] = CLK_EN;
          cnt_n[d] = clk_cycles_i;
        end
        CLK_EN: if (!eff_en[d]) begin
          state_n[d] = RST_ASSERT;
          cnt_n[d] = rst_cycles_i;
        end else if (cnt_q[d] == '0) state_n[d] = ON;
        ON: if (!eff_en[d]) begin
          state_n[d] = RST_ASSERT;
          cnt_n[d] = rst_cycles_i;
        end else if (sw_rst_i[d]) begin
          state_n[d] = SW_RST;
          cnt_n[d] = rst_cycles_i;
        end
        SW_RST: if (cnt_q[d] == '0) begin
          state_n[d] = eff_en[d] ? ON : RST_ASSERT;
          cnt_n[d] = eff_en[d] ? cnt_q[d] : rst_cycles_i;
        end
        RST_ASSERT: if (cnt_q[d] == '0) state_n[d] = OFF;
        default: state_n[d] = OFF;
      endcase
      want[d] = (state_q[d] == OFF || state_q[d] == ON) && state_n[d] != state_q[d];
    end
  end
`ifdef CARFIELD_DOMAIN_SEQ_SERIAL_EN
  // Lowest-index requester wins, and only while no domain is busy.
  assign grant = (|busy_o) ? '0 : want & (~want + NumDomains'(1));
`else
  assign grant = want;
`endif
  assign hold = want & ~grant;
  always_ff @(posedge clk_i) begin
    for (int d = 0; d < NumDomains; d++) begin
      if (rst_i) begin
        state_q[d] <= OFF;
        cnt_q[d] <= '0;
      end else if (!hold[d]) begin
        state_q[d] <= state_n[d];
        cnt_q[d] <= cnt_n[d];
      end
    end
  end
  always_comb begin
    domain_clk_en_o = '0;
    domain_rst_no = '0;
    active_o = '0;
    busy_o = '0;
    for (int d = 0; d < NumDomains; d++) begin
      domain_clk_en_o[d] = state_q[d] != OFF;
      domain_rst_no[d] = state_q[d] == ON;
      active_o[d] = state_q[d] == ON;
      busy_o[d] = state_q[d] inside {CLK_EN, SW_RST, RST_ASSERT};
    end
  end
endmodule
